// File: rtl/data_bus_pkg.sv
// Shared types and constants for the data-side bus controller.
// Holds the outstanding-transaction tracker states and the register map.
package data_bus_pkg;

    typedef enum logic [1:0] {
        PEND_NONE = 2'd0,
        PEND_RAM  = 2'd1,
        PEND_LOC  = 2'd2,
        PEND_ERR  = 2'd3
    } pend_e;

    localparam logic [1:0]  REG_FLAG   = 2'd0;
    localparam logic [1:0]  REG_RESULT = 2'd1;
    localparam logic [1:0]  REG_CYCLE  = 2'd2;
    localparam logic [1:0]  REG_ID     = 2'd3;

    localparam logic [31:0] REG_ID_VALUE        = 32'h5A10_0001;
    localparam logic [31:0] DEFAULT_PERIPH_BASE = 32'h0001_0000;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/periph_regs.sv
// Local register block: FLAG and RESULT (byte-writable), free-running CYCLE, constant ID.
// Read data is combinational on addr; the caller latches it at grant.
module periph_regs
    import data_bus_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        we,
    input  logic [3:0]  be,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [31:0] mem_flag,
    output logic [31:0] mem_result
);

    logic [31:0] cycle_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_flag   <= '0;
            mem_result <= '0;
            cycle_q    <= '0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
            // CYCLE and ID are read-only; writes to them are silently dropped
            if (we && addr == REG_FLAG)   mem_flag   <= byte_merge(mem_flag, wdata, be);
            if (we && addr == REG_RESULT) mem_result <= byte_merge(mem_result, wdata, be);
        end
    end

    always_comb begin
        case (addr)
            REG_FLAG:   rdata = mem_flag;
            REG_RESULT: rdata = mem_result;
            REG_CYCLE:  rdata = cycle_q;
            default:    rdata = REG_ID_VALUE;
        endcase
    end

endmodule

// File: rtl/data_bus_ctrl.sv
// Data-side bus controller: decodes core requests to RAM, local registers or an
// error slave, tracks the single outstanding transaction and muxes the response.
module data_bus_ctrl
    import data_bus_pkg::*;
#(
    parameter int          RAM_WORDS   = 1024,
    parameter logic [31:0] PERIPH_BASE = DEFAULT_PERIPH_BASE
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    output logic        ram_req_o,
    input  logic        ram_gnt_i,
    input  logic        ram_rvalid_i,
    output logic        ram_we_o,
    output logic [3:0]  ram_be_o,
    output logic [31:0] ram_addr_o,
    output logic [31:0] ram_wdata_o,
    input  logic [31:0] ram_rdata_i,
    output logic [31:0] mem_flag,
    output logic [31:0] mem_result
);

    localparam logic [32:0] RAM_LIMIT = 33'(RAM_WORDS) << 2;

    pend_e       pend_p1;
    logic [31:0] rdata_p1;
    logic [31:0] reg_rdata;
    logic        is_ram;
    logic        is_periph;
    logic        can_accept;
    logic        local_gnt;
    logic        ram_gnt_ok;
    logic        reg_we;

    assign is_ram    = {1'b0, data_addr_i} < RAM_LIMIT;
    assign is_periph = data_addr_i[31:4] == PERIPH_BASE[31:4];

    // A pending local/error access always retires this cycle, so only RAM can stall
    assign can_accept = (pend_p1 != PEND_RAM) | ram_rvalid_i;

    assign ram_req_o  = data_req_i & is_ram & can_accept & ~rst_i;
    assign local_gnt  = data_req_i & ~is_ram & can_accept & ~rst_i;
    assign ram_gnt_ok = ram_req_o & ram_gnt_i;
    assign data_gnt_o = ram_gnt_ok | local_gnt;
    assign reg_we     = local_gnt & is_periph & data_we_i;

    assign ram_we_o    = data_we_i;
    assign ram_be_o    = data_be_i;
    assign ram_addr_o  = data_addr_i;
    assign ram_wdata_o = data_wdata_i;

    periph_regs u_regs (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .we         (reg_we),
        .be         (data_be_i),
        .addr       (data_addr_i[3:2]),
        .wdata      (data_wdata_i),
        .rdata      (reg_rdata),
        .mem_flag   (mem_flag),
        .mem_result (mem_result)
    );

    // Grant stage -> response stage
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_p1  <= PEND_NONE;
            rdata_p1 <= '0;
        end else begin
            if (ram_gnt_ok)                          pend_p1 <= PEND_RAM;
            else if (local_gnt)                      pend_p1 <= is_periph ? PEND_LOC : PEND_ERR;
            else if (pend_p1 != PEND_RAM || ram_rvalid_i) pend_p1 <= PEND_NONE;

            if (local_gnt && is_periph) rdata_p1 <= reg_rdata;
        end
    end

    always_comb begin
        data_rvalid_o = 1'b0;
        data_rdata_o  = '0;
        data_err_o    = 1'b0;
        case (pend_p1)
            PEND_RAM: begin
                data_rvalid_o = ram_rvalid_i;
                data_rdata_o  = ram_rdata_i;
            end
            PEND_LOC: begin
                data_rvalid_o = 1'b1;
                data_rdata_o  = rdata_p1;
            end
            PEND_ERR: begin
                data_rvalid_o = 1'b1;
                data_err_o    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_data_bus_ctrl.sv
// Bench for data_bus_ctrl: directed vector table, hand-written corner sequences,
// then randomized traffic scored against a transaction-level reference model.
module tb_data_bus_ctrl;

    localparam int          RAM_WORDS = 1024;
    localparam logic [31:0] PB        = 32'h0001_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        gnt;
    logic        rvalid;
    logic        we = 1'b0;
    logic [3:0]  be = 4'h0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        err;
    logic        ram_req;
    logic        ram_gnt = 1'b1;
    logic        ram_rvalid;
    logic        ram_we;
    logic [3:0]  ram_be;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic [31:0] mem_flag;
    logic [31:0] mem_result;
    int          ram_lat = 1;

    data_bus_ctrl #(.RAM_WORDS(RAM_WORDS), .PERIPH_BASE(PB)) dut (
        .clk_i(clk), .rst_i(rst),
        .data_req_i(req), .data_gnt_o(gnt), .data_rvalid_o(rvalid),
        .data_we_i(we), .data_be_i(be), .data_addr_i(addr), .data_wdata_i(wdata),
        .data_rdata_o(rdata), .data_err_o(err),
        .ram_req_o(ram_req), .ram_gnt_i(ram_gnt), .ram_rvalid_i(ram_rvalid),
        .ram_we_o(ram_we), .ram_be_o(ram_be), .ram_addr_o(ram_addr),
        .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata),
        .mem_flag(mem_flag), .mem_result(mem_result)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] b);
        logic [31:0] m;
        m = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
        return (old_v & ~m) | (new_v & m);
    endfunction

    function automatic logic [31:0] init_word(input int i);
        if (i == 64) return 32'hCAFE_F00D;
        return (32'(i) * 32'h9E37_79B9) ^ 32'h1357_9BDF;
    endfunction

    // ---------------- RAM model with programmable latency ----------------
    logic [31:0] ram_mem [RAM_WORDS];
    logic        ram_pend;
    int          ram_cnt;
    logic [31:0] ram_hold;

    always @(posedge clk or posedge rst) begin : ram_model
        int          idx;
        logic [31:0] rd;
        if (rst) begin
            ram_rvalid <= 1'b0;
            ram_rdata  <= '0;
            ram_pend   <= 1'b0;
            ram_cnt    <= 0;
            ram_hold   <= '0;
            for (int i = 0; i < RAM_WORDS; i++) ram_mem[i] <= init_word(i);
        end else begin
            ram_rvalid <= 1'b0;
            if (ram_pend) begin
                if (ram_cnt <= 1) begin
                    ram_rvalid <= 1'b1;
                    ram_rdata  <= ram_hold;
                    ram_pend   <= 1'b0;
                end else begin
                    ram_cnt <= ram_cnt - 1;
                end
            end
            if (ram_req && ram_gnt) begin
                idx = int'(ram_addr[11:2]);
                rd  = ram_mem[idx];
                if (ram_we) ram_mem[idx] <= merge(rd, ram_wdata, ram_be);
                if (ram_lat <= 1) begin
                    ram_rvalid <= 1'b1;
                    ram_rdata  <= rd;
                end else begin
                    ram_pend <= 1'b1;
                    ram_cnt  <= ram_lat - 1;
                    ram_hold <= rd;
                end
            end
        end
    end

    // Non-reset clock edges seen so far: what the CYCLE register should hold
    logic [31:0] edge_cnt;
    always @(posedge clk or posedge rst) begin
        if (rst) edge_cnt <= '0;
        else     edge_cnt <= edge_cnt + 32'd1;
    end

    // ---------------- reference model ----------------
    typedef struct {
        int          wait_n;
        logic        err;
        logic        is_rd;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] ref_mem [RAM_WORDS];
    logic [31:0] ref_flag;
    logic [31:0] ref_result;

    task automatic model_reset();
        for (int i = 0; i < RAM_WORDS; i++) ref_mem[i] = init_word(i);
        ref_flag   = '0;
        ref_result = '0;
        sbq.delete();
    endtask

    task automatic step(input logic r, input logic [31:0] a, input logic w, input logic [3:0] b,
                        input logic [31:0] wd, input logic gen, input int lat);
        exp_t e;
        logic can, t_ram, t_per, exp_gnt;
        int   idx;
        @(negedge clk);
        chk("rnd_flag", mem_flag, ref_flag);
        chk("rnd_result", mem_result, ref_result);
        if (sbq.size() > 0) begin
            e = sbq[0];
            e.wait_n--;
            if (e.wait_n == 0) begin
                chk1("rnd_rvalid", rvalid, 1'b1);
                chk1("rnd_err", err, e.err);
                if (e.is_rd) chk("rnd_rdata", rdata, e.rdata);
                void'(sbq.pop_front());
            end else begin
                chk1("rnd_rvalid_wait", rvalid, 1'b0);
                sbq[0] = e;
            end
        end else begin
            chk1("rnd_rvalid_idle", rvalid, 1'b0);
        end
        can = (sbq.size() == 0);
        req = r; addr = a; we = w; be = b; wdata = wd; ram_gnt = gen; ram_lat = lat;
        #1;
        t_ram   = a < 32'(4 * RAM_WORDS);
        t_per   = (a & 32'hFFFF_FFF0) == PB;
        exp_gnt = r && can && (!t_ram || gen);
        chk1("rnd_gnt", gnt, exp_gnt);
        chk1("rnd_ram_req", ram_req, r && can && t_ram);
        if (exp_gnt) begin
            e.err = 1'b0; e.is_rd = !w; e.wait_n = 1; e.rdata = '0;
            if (t_ram) begin
                idx = int'(a[11:2]);
                e.rdata  = ref_mem[idx];
                e.wait_n = lat;
                if (w) ref_mem[idx] = merge(ref_mem[idx], wd, b);
            end else if (t_per) begin
                case (a[3:2])
                    2'd0: e.rdata = ref_flag;
                    2'd1: e.rdata = ref_result;
                    2'd2: e.rdata = edge_cnt;
                    default: e.rdata = 32'h5A10_0001;
                endcase
                if (w && a[3:2] == 2'd0) ref_flag   = merge(ref_flag, wd, b);
                if (w && a[3:2] == 2'd1) ref_result = merge(ref_result, wd, b);
            end else begin
                e.err = 1'b1; e.is_rd = 1'b1;
            end
            sbq.push_back(e);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk1({tag, "_gnt"}, gnt, 1'b0);
        chk1({tag, "_ram_req"}, ram_req, 1'b0);
        chk1({tag, "_rvalid"}, rvalid, 1'b0);
        chk1({tag, "_err"}, err, 1'b0);
        chk({tag, "_rdata"}, rdata, 32'h0);
        chk({tag, "_flag"}, mem_flag, 32'h0);
        chk({tag, "_result"}, mem_result, 32'h0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [31:0] a;
        logic        w;
        logic [3:0]  b;
        logic [31:0] wd;
        logic        exp_err;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic [31:0] exp_flag;
        logic [31:0] exp_result;
    } vec_t;

    vec_t vt[12];

    task automatic check_vec(input int k);
        chk1("tbl_rvalid", rvalid, 1'b1);
        chk1("tbl_err", err, vt[k].exp_err);
        if (vt[k].chk_rd) chk("tbl_rdata", rdata, vt[k].exp_rd);
        chk("tbl_flag", mem_flag, vt[k].exp_flag);
        chk("tbl_result", mem_result, vt[k].exp_result);
    endtask

    initial begin : main
        logic [31:0] c0;
        vt[0]  = '{PB + 32'h0, 1'b1, 4'hF, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0,          32'hDEAD_BEEF, 32'h0};
        vt[1]  = '{PB + 32'h4, 1'b1, 4'h5, 32'h1122_3344, 1'b0, 1'b0, 32'h0,          32'hDEAD_BEEF, 32'h0022_0044};
        vt[2]  = '{PB + 32'h0, 1'b0, 4'hF, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF,  32'hDEAD_BEEF, 32'h0022_0044};
        vt[3]  = '{PB + 32'h4, 1'b0, 4'hF, 32'h0,         1'b0, 1'b1, 32'h0022_0044,  32'hDEAD_BEEF, 32'h0022_0044};
        vt[4]  = '{PB + 32'hC, 1'b0, 4'hF, 32'h0,         1'b0, 1'b1, 32'h5A10_0001,  32'hDEAD_BEEF, 32'h0022_0044};
        vt[5]  = '{PB + 32'hC, 1'b1, 4'hF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0,          32'hDEAD_BEEF, 32'h0022_0044};
        vt[6]  = '{PB + 32'hC, 1'b0, 4'hF, 32'h0,         1'b0, 1'b1, 32'h5A10_0001,  32'hDEAD_BEEF, 32'h0022_0044};
        vt[7]  = '{PB + 32'h0, 1'b1, 4'h0, 32'h1234_5678, 1'b0, 1'b0, 32'h0,          32'hDEAD_BEEF, 32'h0022_0044};
        vt[8]  = '{PB + 32'h0, 1'b1, 4'h8, 32'hAA00_0000, 1'b0, 1'b0, 32'h0,          32'hAAAD_BEEF, 32'h0022_0044};
        vt[9]  = '{32'h8000_0000, 1'b0, 4'hF, 32'h0,      1'b1, 1'b1, 32'h0,          32'hAAAD_BEEF, 32'h0022_0044};
        vt[10] = '{32'h0000_1000, 1'b1, 4'hF, 32'h5555_5555, 1'b1, 1'b1, 32'h0,       32'hAAAD_BEEF, 32'h0022_0044};
        vt[11] = '{PB + 32'h10, 1'b0, 4'hF, 32'h0,        1'b1, 1'b1, 32'h0,          32'hAAAD_BEEF, 32'h0022_0044};

        // Reset with a live request on the bus: nothing may be granted
        req = 1'b1; addr = PB; we = 1'b1; be = 4'hF; wdata = 32'hFFFF_FFFF;
        @(negedge clk);
        check_reset_outputs("rst0");
        addr = 32'h0000_0040;
        #1 check_reset_outputs("rst0_ram");
        @(negedge clk);
        req = 1'b0; rst = 1'b0;

        // Table vectors issued back to back
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i > 0) check_vec(i - 1);
            req = 1'b1; addr = vt[i].a; we = vt[i].w; be = vt[i].b; wdata = vt[i].wd;
            ram_gnt = 1'b1;
            #1;
            chk1("tbl_gnt", gnt, 1'b1);
            chk1("tbl_no_ram_req", ram_req, 1'b0);
        end
        @(negedge clk);
        check_vec(11);
        req = 1'b0;

        // RAM read of preloaded word
        @(negedge clk);
        chk1("idle_rvalid", rvalid, 1'b0);
        req = 1'b1; addr = 32'h0000_0100; we = 1'b0; be = 4'hF; ram_gnt = 1'b1; ram_lat = 1;
        #1;
        chk1("ram_rd_req", ram_req, 1'b1);
        chk1("ram_rd_gnt", gnt, 1'b1);
        chk("ram_rd_addr", ram_addr, 32'h0000_0100);
        @(negedge clk);
        req = 1'b0;
        chk1("ram_rd_rvalid", rvalid, 1'b1);
        chk("ram_rd_rdata", rdata, 32'hCAFE_F00D);
        chk1("ram_rd_err", err, 1'b0);

        // Last RAM word: write pass-through then read back
        @(negedge clk);
        req = 1'b1; addr = 32'h0000_0FFC; we = 1'b1; be = 4'h3; wdata = 32'h0BAD_C0DE;
        #1;
        chk1("ram_wr_req", ram_req, 1'b1);
        chk1("ram_wr_we", ram_we, 1'b1);
        chk("ram_wr_be", 32'(ram_be), 32'h3);
        chk("ram_wr_wdata", ram_wdata, 32'h0BAD_C0DE);
        @(negedge clk);
        chk1("ram_wr_rvalid", rvalid, 1'b1);
        we = 1'b0;
        @(negedge clk);
        req = 1'b0;
        chk1("ram_rb_rvalid", rvalid, 1'b1);
        chk("ram_rb_rdata", rdata, merge(init_word(1023), 32'h0BAD_C0DE, 4'h3));

        // Two CYCLE reads granted back to back
        @(negedge clk);
        req = 1'b1; addr = PB + 32'h8; we = 1'b0; be = 4'hF;
        #1;
        c0 = edge_cnt;
        chk1("cyc_gnt0", gnt, 1'b1);
        @(negedge clk);
        chk1("cyc_rvalid0", rvalid, 1'b1);
        chk("cyc_val0", rdata, c0);
        #1 chk1("cyc_gnt1", gnt, 1'b1);
        @(negedge clk);
        req = 1'b0;
        chk1("cyc_rvalid1", rvalid, 1'b1);
        chk("cyc_val1", rdata, c0 + 32'd1);

        // Counter wrap
        @(negedge clk);
        force dut.u_regs.cycle_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.u_regs.cycle_q;
        #1;
        req = 1'b1; addr = PB + 32'h8; we = 1'b0;
        @(negedge clk);
        chk("cyc_max", rdata, 32'hFFFF_FFFF);
        @(negedge clk);
        req = 1'b0;
        chk("cyc_wrap", rdata, 32'h0);

        // Peripheral request stalls behind a slow RAM read, granted with its rvalid
        @(negedge clk);
        req = 1'b1; addr = 32'h0000_0200; we = 1'b0; ram_gnt = 1'b1; ram_lat = 3;
        #1 chk1("stall_ram_gnt", gnt, 1'b1);
        @(negedge clk);
        chk1("stall_rvalid1", rvalid, 1'b0);
        addr = PB;
        #1 chk1("stall_gnt1", gnt, 1'b0);
        @(negedge clk);
        chk1("stall_rvalid2", rvalid, 1'b0);
        #1 chk1("stall_gnt2", gnt, 1'b0);
        @(negedge clk);
        chk1("stall_rvalid3", rvalid, 1'b1);
        chk("stall_ram_rdata", rdata, init_word(128));
        #1 chk1("stall_gnt3", gnt, 1'b1);
        @(negedge clk);
        req = 1'b0;
        chk1("stall_loc_rvalid", rvalid, 1'b1);
        chk1("stall_loc_err", err, 1'b0);
        chk("stall_loc_rdata", rdata, 32'hAAAD_BEEF);

        // Reset while a RAM read is outstanding
        @(negedge clk);
        req = 1'b1; addr = 32'h0000_0300; we = 1'b0; ram_lat = 3;
        #1 chk1("mid_rst_gnt", gnt, 1'b1);
        @(negedge clk);
        req = 1'b0; rst = 1'b1;
        #1 check_reset_outputs("mid_rst");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk1("post_rst_rvalid", rvalid, 1'b0);
        end
        model_reset();

        // Randomized traffic
        for (int n = 0; n < 800; n++) begin
            logic [31:0] a;
            int          sel;
            sel = $urandom_range(0, 9);
            if (sel < 4) a = {20'h0, 10'($urandom_range(0, RAM_WORDS - 1)), 2'b00};
            else if (sel < 8) a = PB + {28'h0, 2'($urandom_range(0, 3)), 2'b00};
            else begin
                case ($urandom_range(0, 3))
                    0: a = 32'h8000_0000;
                    1: a = 32'h0000_1000;
                    2: a = PB + 32'h10;
                    default: a = 32'h0002_0000 | ($urandom & 32'hFFFF_FFFC);
                endcase
            end
            step($urandom_range(0, 9) < 7, a, 1'($urandom_range(0, 1)), 4'($urandom),
                 $urandom, $urandom_range(0, 4) != 0, $urandom_range(1, 3));
        end
        for (int n = 0; n < 6; n++) step(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1, 1);
        chk("drain_queue", 32'(sbq.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
